// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register with flush bubbles and halt freeze.
// Optional FETCH_REDIRECT_CNT_EN adds a saturating counter of taken redirects.
module fetch_pc_unit #(
  parameter int                       PC_WIDTH    = 16,
  parameter int                       INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]      RESET_PC    = 16'h0000,
  parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR   = 16'hF000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             PCsrc,
  input  logic                   flush,
  input  logic                   stall,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic [PC_WIDTH-1:0]    jump_target,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus2,
  output logic                   if_id_valid,
  output logic                   halted,
  output logic [15:0]            redirect_count
);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HALT   = 2'b11;

  state_t r_state;
  state_t w_state_next;

  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_if_id_instr;
  logic [PC_WIDTH-1:0]    r_if_id_pc_plus2;
  logic                   r_if_id_valid;

  logic [PC_WIDTH-1:0]    w_pc_next;
  logic [INSTR_WIDTH-1:0] w_if_id_instr_next;
  logic [PC_WIDTH-1:0]    w_if_id_pc_plus2_next;
  logic                   w_if_id_valid_next;
  logic [PC_WIDTH-1:0]    w_pc_plus2;
  logic                   w_redirect;

  // Wraps naturally modulo 2^PC_WIDTH.
  assign w_pc_plus2 = r_pc + {{(PC_WIDTH-2){1'b0}}, 2'b10};
  assign w_redirect = (r_state == S_RUN) &&
                      ((PCsrc == PCSRC_BRANCH) || (PCsrc == PCSRC_JUMP));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_START;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_START: w_state_next = S_RUN;
      S_RUN:   if (PCsrc == PCSRC_HALT) w_state_next = S_HALT;
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_START;
    endcase
  end

  // Output logic
  always_comb begin
    halted = (r_state == S_HALT);
  end

  // Datapath next values; everything holds unless a case below loads it.
  always_comb begin
    w_pc_next             = r_pc;
    w_if_id_instr_next    = r_if_id_instr;
    w_if_id_pc_plus2_next = r_if_id_pc_plus2;
    w_if_id_valid_next    = r_if_id_valid;
    case (r_state)
      S_START: begin
        w_pc_next             = w_pc_plus2;
        w_if_id_instr_next    = imem_rdata;
        w_if_id_pc_plus2_next = w_pc_plus2;
        w_if_id_valid_next    = 1'b1;
      end
      S_RUN: begin
        if (PCsrc == PCSRC_HALT) begin
          w_if_id_instr_next = NOP_INSTR;
          w_if_id_valid_next = 1'b0;
        end else begin
          // A redirect wins over stall for the PC, but IF/ID still honours stall.
          if (PCsrc == PCSRC_BRANCH) begin
            w_pc_next = branch_target;
          end else if (PCsrc == PCSRC_JUMP) begin
            w_pc_next = jump_target;
          end else if (!stall && (PCsrc == PCSRC_SEQ)) begin
            w_pc_next = w_pc_plus2;
          end

          if (flush) begin
            w_if_id_instr_next = NOP_INSTR;
            w_if_id_valid_next = 1'b0;
          end else if (!stall) begin
            w_if_id_instr_next    = imem_rdata;
            w_if_id_pc_plus2_next = w_pc_plus2;
            w_if_id_valid_next    = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc             <= RESET_PC;
      r_if_id_instr    <= NOP_INSTR;
      r_if_id_pc_plus2 <= '0;
      r_if_id_valid    <= 1'b0;
    end else begin
      r_pc             <= w_pc_next;
      r_if_id_instr    <= w_if_id_instr_next;
      r_if_id_pc_plus2 <= w_if_id_pc_plus2_next;
      r_if_id_valid    <= w_if_id_valid_next;
    end
  end

`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0] r_redirect_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_count <= '0;
    end else if (w_redirect && (r_redirect_count != 16'hFFFF)) begin
      r_redirect_count <= r_redirect_count + 16'd1;
    end
  end

  assign redirect_count = r_redirect_count;
`else
  logic w_redirect_unused;
  assign w_redirect_unused = w_redirect;
  assign redirect_count    = 16'h0000;
`endif

  assign imem_addr      = r_pc;
  assign pc             = r_pc;
  assign if_id_instr    = r_if_id_instr;
  assign if_id_pc_plus2 = r_if_id_pc_plus2;
  assign if_id_valid    = r_if_id_valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, flushed branch, stall, jump, halt, wrap, reset.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PCsrc;
  logic        flush;
  logic        stall;
  logic [15:0] branch_target;
  logic [15:0] jump_target;
  logic [15:0] imem_rdata;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] redirect_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_redir = 0;

  always #5 clk = ~clk;

  // Address-derived instruction pattern; never equals the NOP encoding for the addresses used.
  assign imem_rdata = imem_addr ^ 16'h5A00;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .PCsrc          (PCsrc),
    .flush          (flush),
    .stall          (stall),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .imem_rdata     (imem_rdata),
    .imem_addr      (imem_addr),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .redirect_count (redirect_count)
  );

  function automatic logic [15:0] rd(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_redir(input string tag);
`ifdef FETCH_REDIRECT_CNT_EN
    check_eq(tag, {16'h0, redirect_count}, exp_redir);
`else
    check_eq(tag, {16'h0, redirect_count}, 32'h0);
`endif
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] e_pc, input logic [15:0] e_instr,
                            input logic e_valid);
    check_eq({tag, ".pc"}, {16'h0, pc}, {16'h0, e_pc});
    check_eq({tag, ".addr"}, {16'h0, imem_addr}, {16'h0, e_pc});
    check_eq({tag, ".instr"}, {16'h0, if_id_instr}, {16'h0, e_instr});
    check_eq({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e_valid});
    $display("txn %s: pc=%h instr=%h pcp2=%h valid=%0d halted=%0d rc=%0d",
             tag, pc, if_id_instr, if_id_pc_plus2, if_id_valid, halted, redirect_count);
  endtask

  initial begin
    rst = 1'b1; PCsrc = 2'b00; flush = 1'b0; stall = 1'b0;
    branch_target = 16'h0; jump_target = 16'h0;
    tick(); tick();
    check_ifid("reset", 16'h0000, 16'hF000, 1'b0);
    check_eq("reset.pcp2", {16'h0, if_id_pc_plus2}, 32'h0);
    check_eq("reset.halted", {31'h0, halted}, 32'h0);
    check_redir("reset.rc");

    // Start cycle ignores inputs even if they request a redirect.
    rst = 1'b0; PCsrc = 2'b10; jump_target = 16'h0300; flush = 1'b1;
    tick();
    PCsrc = 2'b00; flush = 1'b0;
    check_ifid("start", 16'h0002, rd(16'h0000), 1'b1);
    check_eq("start.pcp2", {16'h0, if_id_pc_plus2}, 32'h0002);
    tick(); check_ifid("seq1", 16'h0004, rd(16'h0002), 1'b1);
    tick(); check_ifid("seq2", 16'h0006, rd(16'h0004), 1'b1);
    check_eq("seq2.pcp2", {16'h0, if_id_pc_plus2}, 32'h0006);

    // Flushed branch: one bubble then the target instruction.
    PCsrc = 2'b01; branch_target = 16'h0040; flush = 1'b1;
    tick(); exp_redir++;
    PCsrc = 2'b00; flush = 1'b0;
    check_ifid("br_bubble", 16'h0040, 16'hF000, 1'b0);
    check_redir("br.rc");
    tick(); check_ifid("br_target", 16'h0042, rd(16'h0040), 1'b1);
    check_eq("br_target.pcp2", {16'h0, if_id_pc_plus2}, 32'h0042);

    // Unflushed jump: wrong-path instruction remains valid.
    PCsrc = 2'b10; jump_target = 16'h0010;
    tick(); exp_redir++;
    PCsrc = 2'b00;
    check_ifid("jmp", 16'h0010, rd(16'h0042), 1'b1);
    check_redir("jmp.rc");

    stall = 1'b1;
    tick(); check_ifid("stall1", 16'h0010, rd(16'h0042), 1'b1);
    tick(); check_ifid("stall2", 16'h0010, rd(16'h0042), 1'b1);
    stall = 1'b0;
    tick(); check_ifid("release", 16'h0012, rd(16'h0010), 1'b1);

    // Jump overrides stall for the PC; IF/ID still holds.
    stall = 1'b1; PCsrc = 2'b10; jump_target = 16'h0100;
    tick(); exp_redir++;
    stall = 1'b0; PCsrc = 2'b00;
    check_ifid("stall_jmp", 16'h0100, rd(16'h0010), 1'b1);
    check_redir("stall_jmp.rc");
    tick(); check_ifid("after_sj", 16'h0102, rd(16'h0100), 1'b1);

    PCsrc = 2'b10; jump_target = 16'h0020;
    tick(); exp_redir++;
    PCsrc = 2'b00;
    check_eq("to20.pc", {16'h0, pc}, 32'h0020);

    // Halt and stay frozen.
    PCsrc = 2'b11;
    tick();
    check_ifid("halt", 16'h0020, 16'hF000, 1'b0);
    check_eq("halt.halted", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      PCsrc = 2'(i); flush = i[0]; stall = i[1];
      branch_target = 16'h0800 + 16'(i); jump_target = 16'h0900 + 16'(i);
      tick();
      check_eq("halt_hold.pc", {16'h0, pc}, 32'h0020);
      check_eq("halt_hold.halted", {31'h0, halted}, 32'h1);
      check_eq("halt_hold.valid", {31'h0, if_id_valid}, 32'h0);
    end
    check_redir("halt.rc");
    PCsrc = 2'b00; flush = 1'b0; stall = 1'b0;

    rst = 1'b1;
    tick(); exp_redir = 0;
    check_ifid("unhalt_rst", 16'h0000, 16'hF000, 1'b0);
    check_eq("unhalt_rst.halted", {31'h0, halted}, 32'h0);
    check_redir("unhalt_rst.rc");

    // PC wrap.
    rst = 1'b0;
    tick(); check_eq("restart.pc", {16'h0, pc}, 32'h0002);
    PCsrc = 2'b10; jump_target = 16'hFFFC;
    tick(); exp_redir++;
    PCsrc = 2'b00;
    check_eq("wrap0.pc", {16'h0, pc}, 32'hFFFC);
    tick(); check_ifid("wrap1", 16'hFFFE, rd(16'hFFFC), 1'b1);
    tick(); check_ifid("wrap2", 16'h0000, rd(16'hFFFE), 1'b1);
    check_eq("wrap2.pcp2", {16'h0, if_id_pc_plus2}, 32'h0000);
    check_redir("wrap.rc");

    // Reset during stall.
    stall = 1'b1;
    tick(); check_ifid("pre_rst_stall", 16'h0000, rd(16'hFFFE), 1'b1);
    rst = 1'b1;
    tick(); exp_redir = 0;
    check_ifid("rst_stall", 16'h0000, 16'hF000, 1'b0);
    check_redir("rst_stall.rc");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
